sdrc_req_gen: RTL

SDRC_REQ_GEN -- requirements
Module: sdrc_req_gen

---
 rtl/sdrc_pkg.sv | 32 +++
 rtl/sdrc_addr_map.sv | 31 +++
 rtl/sdrc_req_gen.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sdrc_pkg.sv
// Shared definitions for the SDRAM request generator: FSM states,
// column-bit encodings and default field widths.
package sdrc_pkg;

  localparam int DEF_APP_AW = 26;
  localparam int DEF_LEN_W  = 9;
  localparam int DEF_ROW_W  = 13;
  localparam int DEF_COL_W  = 11;

  localparam logic [1:0] COLBITS_8  = 2'b00;
  localparam logic [1:0] COLBITS_9  = 2'b01;
  localparam logic [1:0] COLBITS_10 = 2'b10;
  localparam logic [1:0] COLBITS_11 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  // Number of column address bits selected by the cfg_colbits encoding.
  function automatic logic [3:0] colbits_num(input logic [1:0] enc);
    colbits_num = 4'd11;
    unique case (enc)
      COLBITS_8:  colbits_num = 4'd8;
      COLBITS_9:  colbits_num = 4'd9;
      COLBITS_10: colbits_num = 4'd10;
      COLBITS_11: colbits_num = 4'd11;
    endcase
  endfunction

endpackage

// File: rtl/sdrc_addr_map.sv
// Combinational split of a linear word address into SDRAM bank, row and
// column for the configured column width.
module sdrc_addr_map import sdrc_pkg::*; #(
  parameter int APP_AW = DEF_APP_AW,
  parameter int ROW_W  = DEF_ROW_W,
  parameter int COL_W  = DEF_COL_W
) (
  input  logic [APP_AW-1:0] addr,
  input  logic [1:0]        colbits,
  output logic [1:0]        ba,
  output logic [ROW_W-1:0]  raddr,
  output logic [COL_W-1:0]  caddr
);

  // Zero-extended far enough that row bits above the address MSB read as 0.
  localparam int EXT_W = APP_AW + ROW_W + COL_W + 2;

  logic [3:0]       cb;
  logic [EXT_W-1:0] ext;
  logic [COL_W-1:0] col_mask;

  always_comb begin
    cb       = colbits_num(colbits);
    ext      = EXT_W'(addr);
    col_mask = COL_W'((EXT_W'(1) << cb) - EXT_W'(1));
    caddr    = COL_W'(ext) & col_mask;
    ba       = 2'(ext >> cb);
    raddr    = ROW_W'(ext >> (cb + 4'd2));
  end

endmodule

// File: rtl/sdrc_req_gen.sv
// Splits upstream SDRAM commands into sub-requests that never cross a
// column page and never exceed the configured maximum burst length.
module sdrc_req_gen import sdrc_pkg::*; #(
  parameter int APP_AW = DEF_APP_AW,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int ROW_W  = DEF_ROW_W,
  parameter int COL_W  = DEF_COL_W
) (
  input  logic              sdram_clk,
  input  logic              sdram_resetn,
  input  logic [1:0]        cfg_colbits,
  input  logic [LEN_W-1:0]  cfg_max_len,
  input  logic              req,
  input  logic [APP_AW-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              req_wr_n,
  output logic              req_ack,
  output logic              r2b_req,
  output logic [1:0]        r2b_ba,
  output logic [ROW_W-1:0]  r2b_raddr,
  output logic [COL_W-1:0]  r2b_caddr,
  output logic [LEN_W-1:0]  r2b_len,
  output logic              r2b_write,
  output logic              r2b_start,
  output logic              r2b_last,
  input  logic              b2r_ack,
  output logic              busy
);

  localparam int CMP_W = (LEN_W > COL_W + 1) ? LEN_W : COL_W + 1;

  state_t state, state_nxt;
  logic   accept, load, advance;
  logic   first_chunk;

  logic [APP_AW-1:0] cur_addr;
  logic [LEN_W-1:0]  remaining;
  logic              wr_n_l;
  logic [1:0]        colbits_l;
  logic [LEN_W-1:0]  max_len_l;

  logic [3:0]       cb;
  logic [CMP_W-1:0] page_sz, page_rem, chunk_w;
  logic [LEN_W-1:0] chunk;

  logic [1:0]       map_ba;
  logic [ROW_W-1:0] map_raddr;
  logic [COL_W-1:0] map_caddr;

  sdrc_addr_map #(.APP_AW(APP_AW), .ROW_W(ROW_W), .COL_W(COL_W)) u_addr_map (
    .addr    (cur_addr),
    .colbits (colbits_l),
    .ba      (map_ba),
    .raddr   (map_raddr),
    .caddr   (map_caddr)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) state <= ST_IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;
    unique case (state)
      ST_IDLE: if (req) begin
        accept    = 1'b1;
        state_nxt = ST_CALC;
      end
      ST_CALC: begin
        load      = 1'b1;
        state_nxt = ST_ISSUE;
      end
      ST_ISSUE: if (b2r_ack) begin
        advance   = 1'b1;
        state_nxt = r2b_last ? ST_IDLE : ST_CALC;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Chunk = min(remaining, words left in the column page, max_len if set).
  always_comb begin
    cb       = colbits_num(colbits_l);
    page_sz  = CMP_W'(1) << cb;
    page_rem = page_sz - (CMP_W'(cur_addr) & (page_sz - CMP_W'(1)));
    chunk_w  = CMP_W'(remaining);
    if (page_rem < chunk_w) chunk_w = page_rem;
    if ((max_len_l != '0) && (CMP_W'(max_len_l) < chunk_w)) chunk_w = CMP_W'(max_len_l);
    chunk    = LEN_W'(chunk_w);
  end

  // Command context is only consumed after a fresh accept, so it needs no reset.
  always_ff @(posedge sdram_clk) begin
    if (accept) begin
      cur_addr  <= req_addr;
      remaining <= (req_len == '0) ? LEN_W'(1) : req_len;
      wr_n_l    <= req_wr_n;
      colbits_l <= cfg_colbits;
      max_len_l <= cfg_max_len;
    end else if (advance) begin
      cur_addr  <= cur_addr + APP_AW'(r2b_len);
      remaining <= remaining - r2b_len;
    end
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      req_ack     <= 1'b0;
      r2b_req     <= 1'b0;
      r2b_ba      <= '0;
      r2b_raddr   <= '0;
      r2b_caddr   <= '0;
      r2b_len     <= '0;
      r2b_write   <= 1'b0;
      r2b_start   <= 1'b0;
      r2b_last    <= 1'b0;
      first_chunk <= 1'b0;
    end else begin
      req_ack <= accept;
      if (accept) first_chunk <= 1'b1;
      if (load) begin
        r2b_req   <= 1'b1;
        r2b_ba    <= map_ba;
        r2b_raddr <= map_raddr;
        r2b_caddr <= map_caddr;
        r2b_len   <= chunk;
        r2b_write <= ~wr_n_l;
        r2b_start <= first_chunk;
        r2b_last  <= (chunk == remaining);
      end else if (advance) begin
        r2b_req     <= 1'b0;
        first_chunk <= 1'b0;
      end
    end
  end

endmodule
